// File: rtl/redmule_pkg.sv
// Shared RedMulE types, array geometry and the job-configuration record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package redmule_pkg;

    localparam int unsigned ARRAY_WIDTH  = 16;
    localparam int unsigned ARRAY_HEIGHT = 16;
    localparam int unsigned PIPE_REGS    = 1;
    localparam int unsigned TOT_DEPTH    = 32;
    localparam int unsigned TILE         = (PIPE_REGS + 1) * ARRAY_HEIGHT;

    // Cycles from an accepted start to the done pulse of a full job
    localparam int unsigned CFG_LATENCY  = 5;

    // Field positions inside the MACFG job register
    localparam int unsigned MACFG_OP_LSB  = 10;
    localparam int unsigned MACFG_OP_MSB  = 12;
    localparam int unsigned MACFG_FMT_LSB = 7;
    localparam int unsigned MACFG_FMT_MSB = 8;

    typedef enum logic [2:0] {
        MATMUL = 3'd0, GEMM = 3'd1, ADDMAX = 3'd2, ADDMIN = 3'd3,
        MULMAX = 3'd4, MULMIN = 3'd5, MAXMIN = 3'd6, MINMAX = 3'd7
    } gemm_op_e;

    typedef enum logic [1:0] {
        Float8 = 2'd0, Float16 = 2'd1, Float8Alt = 2'd2, Float16Alt = 2'd3
    } gemm_fmt_e;

    typedef enum logic [2:0] {
        FPU_FP32 = 3'd0, FPU_FP64 = 3'd1, FPU_FP16 = 3'd2,
        FPU_FP8 = 3'd3, FPU_FP16ALT = 3'd4, FPU_FP8ALT = 3'd5
    } fpu_fmt_e;

    typedef enum logic [3:0] {
        FPU_FMADD = 4'd0, FPU_ADD = 4'd2, FPU_MUL = 4'd3, FPU_MINMAX = 4'd7
    } fpu_op_e;

    typedef enum logic [2:0] {
        RNE = 3'd0, RTZ = 3'd1
    } roundmode_e;

    typedef enum logic [2:0] {
        CFG_IDLE, CFG_LATCH, CFG_MUL0, CFG_MUL1, CFG_MUL2, CFG_DONE
    } cfg_state_e;

    typedef struct packed {
        logic [31:0] x_addr;
        logic [31:0] w_addr;
        logic [31:0] z_addr;
        logic [15:0] m_size;
        logic [15:0] n_size;
        logic [15:0] k_size;
        logic [31:0] x_d1_stride;
        logic [31:0] w_d0_stride;
        logic [31:0] yz_d0_stride;
        logic [31:0] yz_d2_stride;
        logic [31:0] x_rows_offs;
        logic [15:0] x_rows_iter;
        logic [15:0] x_cols_iter;
        logic [15:0] w_rows_iter;
        logic [15:0] w_cols_iter;
        logic [7:0]  x_rows_lftovr;
        logic [7:0]  x_cols_lftovr;
        logic [7:0]  w_rows_lftovr;
        logic [7:0]  w_cols_lftovr;
        logic [7:0]  x_buffer_slots;
        logic [15:0] tot_stores;
        logic [31:0] yz_tot_len;
        logic [31:0] x_tot_len;
        logic [31:0] tot_x_read;
        logic [31:0] w_tot_len;
        fpu_op_e     stage_1_op;
        roundmode_e  stage_1_rnd;
        fpu_op_e     stage_2_op;
        roundmode_e  stage_2_rnd;
        gemm_op_e    gemm_ops;
        gemm_fmt_e   gemm_input_fmt;
        gemm_fmt_e   gemm_output_fmt;
        logic        gemm_selection;
        fpu_fmt_e    input_format;
        fpu_fmt_e    computing_format;
    } redmule_config_t;

    // ceil(a / 2^lg) built from a shift and an OR-reduced remainder
    function automatic logic [15:0] ceil_div_pow2(input logic [15:0] a, input int unsigned lg);
        logic [15:0] mask;
        mask = (16'd1 << lg) - 16'd1;
        return (a >> lg) + {15'd0, |(a & mask)};
    endfunction

    // a mod 2^lg; divisors here are small so 8 bits hold the remainder
    function automatic logic [7:0] mod_pow2(input logic [15:0] a, input int unsigned lg);
        logic [15:0] mask;
        mask = (16'd1 << lg) - 16'd1;
        return 8'(a & mask);
    endfunction

endpackage

// File: rtl/redmule_cfg_op_decode.sv
// Maps the GEMM operation and element format onto FPU stage ops/rounding/formats.
// Latency: purely combinational.
// Backpressure: none.
module redmule_cfg_op_decode
    import redmule_pkg::*;
(
    input  gemm_op_e   op,
    input  gemm_fmt_e  fmt,
    output fpu_op_e    stage_1_op,
    output roundmode_e stage_1_rnd,
    output fpu_op_e    stage_2_op,
    output roundmode_e stage_2_rnd,
    output logic       gemm_selection,
    output fpu_fmt_e   input_format,
    output fpu_fmt_e   computing_format
);

    // Operation decode: stage 1 is the element-wise op, stage 2 the reduction
    always_comb begin
        stage_1_op     = FPU_FMADD;
        stage_1_rnd    = RNE;
        stage_2_op     = FPU_FMADD;
        stage_2_rnd    = RNE;
        gemm_selection = 1'b0;
        unique case (op)
            MATMUL: ;
            GEMM:   gemm_selection = 1'b1;
            ADDMAX: begin stage_1_op = FPU_ADD;    stage_2_op = FPU_MINMAX; stage_2_rnd = RTZ; end
            ADDMIN: begin stage_1_op = FPU_ADD;    stage_2_op = FPU_MINMAX; end
            MULMAX: begin stage_1_op = FPU_MUL;    stage_2_op = FPU_MINMAX; stage_2_rnd = RTZ; end
            MULMIN: begin stage_1_op = FPU_MUL;    stage_2_op = FPU_MINMAX; end
            MAXMIN: begin stage_1_op = FPU_MINMAX; stage_1_rnd = RTZ; stage_2_op = FPU_MINMAX; end
            MINMAX: begin stage_1_op = FPU_MINMAX; stage_2_op = FPU_MINMAX; stage_2_rnd = RTZ; end
            default: ;
        endcase
    end

    // Format decode: Alt formats compute in FP16ALT, the others in FP16
    always_comb begin
        input_format     = FPU_FP16;
        computing_format = FPU_FP16;
        unique case (fmt)
            Float8:     input_format = FPU_FP8;
            Float16:    input_format = FPU_FP16;
            Float8Alt:  begin input_format = FPU_FP8ALT;  computing_format = FPU_FP16ALT; end
            Float16Alt: begin input_format = FPU_FP16ALT; computing_format = FPU_FP16ALT; end
            default: ;
        endcase
    end

endmodule

// File: rtl/redmule_cfg_compute.sv
// Latches RedMulE job registers and derives the full redmule_config_t over a fixed sequence (optional zero-size check: REDMULE_CFG_ZERO_CHECK_EN).
// Latency: done_o/cfg_valid_o five cycles after an accepted start (two on a zero-size error).
// Backpressure: none; start_i is ignored while busy, clear_i aborts at any time.
module redmule_cfg_compute
    import redmule_pkg::*;
#(
    parameter int unsigned ARRAY_WIDTH  = redmule_pkg::ARRAY_WIDTH,
    parameter int unsigned ARRAY_HEIGHT = redmule_pkg::ARRAY_HEIGHT,
    parameter int unsigned PIPE_REGS    = redmule_pkg::PIPE_REGS,
    parameter int unsigned TOT_DEPTH    = redmule_pkg::TOT_DEPTH
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clear_i,
    input  logic            start_i,
    input  logic [31:0]     x_addr_i,
    input  logic [31:0]     w_addr_i,
    input  logic [31:0]     z_addr_i,
    input  logic [31:0]     mcfig0_i,
    input  logic [31:0]     mcfig1_i,
    input  logic [31:0]     macfg_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            cfg_valid_o,
    output redmule_config_t cfg_o,
    output logic            err_o
);

    localparam int unsigned TILE_SZ = (PIPE_REGS + 1) * ARRAY_HEIGHT;
    localparam int unsigned LOG_AW  = $clog2(ARRAY_WIDTH);
    localparam int unsigned LOG_AH  = $clog2(ARRAY_HEIGHT);
    localparam int unsigned LOG_TD  = $clog2(TOT_DEPTH);
    localparam int unsigned LOG_TL  = $clog2(TILE_SZ);

    cfg_state_e      state_q, state_d;
    redmule_config_t latch_cfg, work_q, final_cfg, cfg_q;
    logic [31:0]     p0_q, mul_a, mul_p;
    logic [15:0]     mul_b;
    logic            cfg_valid_q, accept, zero_size;

    logic [15:0] m_sz, n_sz, k_sz;
    logic [31:0] n_bytes, k_bytes;
    gemm_op_e    op;
    gemm_fmt_e   fmt;
    logic        wide_elem;

    fpu_op_e    dec_s1_op, dec_s2_op;
    roundmode_e dec_s1_rnd, dec_s2_rnd;
    logic       dec_gsel;
    fpu_fmt_e   dec_in_fmt, dec_cmp_fmt;

    assign m_sz      = mcfig0_i[15:0];
    assign k_sz      = mcfig0_i[31:16];
    assign n_sz      = mcfig1_i[15:0];
    assign op        = gemm_op_e'(macfg_i[MACFG_OP_MSB:MACFG_OP_LSB]);
    assign fmt       = gemm_fmt_e'(macfg_i[MACFG_FMT_MSB:MACFG_FMT_LSB]);
    assign wide_elem = (fmt == Float16) || (fmt == Float16Alt);
    assign n_bytes   = wide_elem ? {15'd0, n_sz, 1'b0} : {16'd0, n_sz};
    assign k_bytes   = wide_elem ? {15'd0, k_sz, 1'b0} : {16'd0, k_sz};
    assign accept    = (state_q == CFG_IDLE) && start_i && !clear_i;

`ifdef REDMULE_CFG_ZERO_CHECK_EN
    assign zero_size = (m_sz == 16'd0) || (n_sz == 16'd0) || (k_sz == 16'd0);
`else
    assign zero_size = 1'b0;
`endif

    redmule_cfg_op_decode u_op_decode (
        .op               (op),
        .fmt              (fmt),
        .stage_1_op       (dec_s1_op),
        .stage_1_rnd      (dec_s1_rnd),
        .stage_2_op       (dec_s2_op),
        .stage_2_rnd      (dec_s2_rnd),
        .gemm_selection   (dec_gsel),
        .input_format     (dec_in_fmt),
        .computing_format (dec_cmp_fmt)
    );

    // Shift/mask-only derivation of everything that needs no multiplier
    always_comb begin
        latch_cfg                  = '0;
        latch_cfg.x_addr           = x_addr_i;
        latch_cfg.w_addr           = w_addr_i;
        latch_cfg.z_addr           = z_addr_i;
        latch_cfg.m_size           = m_sz;
        latch_cfg.n_size           = n_sz;
        latch_cfg.k_size           = k_sz;
        latch_cfg.x_rows_iter      = ceil_div_pow2(m_sz, LOG_AW);
        latch_cfg.x_rows_lftovr    = mod_pow2(m_sz, LOG_AW);
        latch_cfg.x_cols_iter      = ceil_div_pow2(n_sz, LOG_TD);
        latch_cfg.x_cols_lftovr    = mod_pow2(n_sz, LOG_TD);
        latch_cfg.w_rows_iter      = ceil_div_pow2(n_sz, LOG_AH);
        latch_cfg.w_rows_lftovr    = mod_pow2(n_sz, LOG_AH);
        latch_cfg.w_cols_iter      = ceil_div_pow2(k_sz, LOG_TL);
        latch_cfg.w_cols_lftovr    = mod_pow2(k_sz, LOG_TL);
        latch_cfg.x_d1_stride      = n_bytes;
        latch_cfg.w_d0_stride      = k_bytes;
        latch_cfg.yz_d0_stride     = k_bytes;
        latch_cfg.yz_d2_stride     = k_bytes << LOG_AW;
        latch_cfg.x_rows_offs      = n_bytes << LOG_AW;
        latch_cfg.x_buffer_slots   = (latch_cfg.x_cols_lftovr == 8'd0) ? 8'(TOT_DEPTH)
                                                                        : latch_cfg.x_cols_lftovr;
        latch_cfg.stage_1_op       = dec_s1_op;
        latch_cfg.stage_1_rnd      = dec_s1_rnd;
        latch_cfg.stage_2_op       = dec_s2_op;
        latch_cfg.stage_2_rnd      = dec_s2_rnd;
        latch_cfg.gemm_ops         = op;
        latch_cfg.gemm_input_fmt   = fmt;
        latch_cfg.gemm_output_fmt  = fmt;
        latch_cfg.gemm_selection   = dec_gsel;
        latch_cfg.input_format     = dec_in_fmt;
        latch_cfg.computing_format = dec_cmp_fmt;
    end

    // Operand steering for the single shared 32x16 multiplier
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            CFG_MUL0: begin mul_a = {16'd0, work_q.x_rows_iter}; mul_b = work_q.w_cols_iter; end
            CFG_MUL1: begin mul_a = p0_q; mul_b = work_q.x_cols_iter; end
            CFG_MUL2: begin mul_a = p0_q; mul_b = work_q.w_rows_iter; end
            default: ;
        endcase
    end

    assign mul_p = mul_a * {16'd0, mul_b};

    // Last product is folded in on the way to the output register
    always_comb begin
        final_cfg           = work_q;
        final_cfg.w_tot_len = mul_p;
    end

    // Next-state logic; clear overrides everything including a start in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            CFG_IDLE:  if (start_i) state_d = CFG_LATCH;
            CFG_LATCH: state_d = zero_size ? CFG_DONE : CFG_MUL0;
            CFG_MUL0:  state_d = CFG_MUL1;
            CFG_MUL1:  state_d = CFG_MUL2;
            CFG_MUL2:  state_d = CFG_DONE;
            CFG_DONE:  state_d = CFG_IDLE;
            default:   state_d = CFG_IDLE;
        endcase
        if (clear_i) state_d = CFG_IDLE;
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= CFG_IDLE;
        else         state_q <= state_d;
    end

    // Working config: captured in LATCH, products accumulated in MUL0/MUL1
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            work_q <= '0;
            p0_q   <= '0;
        end else if (!clear_i) begin
            case (state_q)
                CFG_LATCH: work_q <= latch_cfg;
                CFG_MUL0: begin
                    p0_q              <= mul_p;
                    work_q.tot_stores <= mul_p[15:0];
                    work_q.yz_tot_len <= mul_p << LOG_AW;
                end
                CFG_MUL1: begin
                    work_q.x_tot_len  <= mul_p;
                    work_q.tot_x_read <= mul_p;
                end
                default: ;
            endcase
        end
    end

    // Published config only changes when a full sequence completes
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                              cfg_q <= '0;
        else if (!clear_i && state_q == CFG_MUL2) cfg_q <= final_cfg;
    end

    // Valid drops on a new job or abort, rises as DONE is entered
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                  cfg_valid_q <= 1'b0;
        else if (clear_i || accept)   cfg_valid_q <= 1'b0;
        else if (state_q == CFG_MUL2) cfg_valid_q <= 1'b1;
    end

`ifdef REDMULE_CFG_ZERO_CHECK_EN
    logic err_q;

    // Sticky zero-size error until the next accepted job or abort
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                                err_q <= 1'b0;
        else if (clear_i || accept)                 err_q <= 1'b0;
        else if (state_q == CFG_LATCH && zero_size) err_q <= 1'b1;
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign busy_o      = (state_q != CFG_IDLE);
    assign done_o      = (state_q == CFG_DONE);
    assign cfg_valid_o = cfg_valid_q;
    assign cfg_o       = cfg_q;

endmodule
